// File: rtl/mul_sched_if.sv
// Requester-side bus of the shared-multiplier scheduler:
// operand pairs in over valid/ready, tagged products back out.
interface mul_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [2*DW-1:0]    rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ
// requesters; one issue per cycle, products routed back in grant order.
module mul_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_sched_if.slave      rq,
  input  logic            hold,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  output logic            mul_en,
  input  logic [2*DW-1:0] mul_res,
  output logic            busy
);
  localparam int CW = $clog2(LAT + 3);

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]         gnt;
  logic [IDW-1:0]          gnt_id;
  logic                    hs;
  int                      idx;

  logic [DW-1:0]           mul_a_q, mul_a_d;
  logic [DW-1:0]           mul_b_q, mul_b_d;
  logic                    mul_en_q, mul_en_d;
  logic [IDW-1:0]          iss_id_q, iss_id_d;
  logic [LAT-1:0]          tag_v_q, tag_v_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [2*DW-1:0]         rsp_data_q, rsp_data_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hs     = 1'b0;
    idx    = 0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!hs && rq.req_valid[idx]) begin
          hs          = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_id      = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    mul_en_d = hs;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    iss_id_d = iss_id_q;
    if (hs) begin
      ptr_d    = IDW'((int'(gnt_id) + 1) % NREQ);
      mul_a_d  = rq.req_a[gnt_id*DW +: DW];
      mul_b_d  = rq.req_b[gnt_id*DW +: DW];
      iss_id_d = gnt_id;
    end
  end

  // Tags trail the issue by one cycle so the last stage meets mul_res.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = mul_en_q;
    tag_id_d[0] = iss_id_q;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (tag_v_q[LAT-1]) begin
      rsp_valid_d = NREQ'(1) << tag_id_q[LAT-1];
      rsp_data_d  = mul_res;
      rsp_id_d    = tag_id_q[LAT-1];
    end
    cnt_d = cnt_q;
    unique case ({hs, |rsp_valid_q})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_en_q    <= 1'b0;
      iss_id_q    <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_en_q    <= mul_en_d;
      iss_id_q    <= iss_id_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rq.req_ready = gnt;
  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_data  = rsp_data_q;
  assign rq.rsp_id    = rsp_id_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_en       = mul_en_q;
  assign busy         = cnt_q != '0;
endmodule

// File: tb/tb_mul_sched.sv
// Testbench for mul_sched: directed scenarios plus randomized traffic
// checked against a queue-based scoreboard of expected responses.
module tb_mul_sched;
  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            hold;
  logic [DW-1:0]   mul_a, mul_b;
  logic            mul_en;
  logic [2*DW-1:0] mul_res;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mul_sched_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) rq ();

  mul_sched #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .rq(rq), .hold(hold),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .mul_res(mul_res), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in pipelined multiplier: product valid LAT cycles after mul_en.
  logic [2*DW-1:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= mul_a * mul_b;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_res = mp[LAT-1];

  // Requester state
  logic [NREQ-1:0] vld;
  logic [DW-1:0]   op_a [NREQ];
  logic [DW-1:0]   op_b [NREQ];

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      rq.req_a[i*DW +: DW] = op_a[i];
      rq.req_b[i*DW +: DW] = op_b[i];
    end
    rq.req_valid = vld;
  endtask

  // Scoreboard model
  typedef struct {
    int              due;
    int              id;
    logic [2*DW-1:0] prod;
  } exp_t;

  exp_t            sb [$];
  int              cyc = 0;
  int              m_ptr = 0;
  logic [NREQ-1:0] m_gnt = '0;
  logic            m_hs_prev = 1'b0;
  logic [DW-1:0]   p_a, p_b, m_mul_a, m_mul_b;
  logic [2*DW-1:0] m_rsp_data;
  logic [IDW-1:0]  m_rsp_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ptr = 0; m_gnt = '0; m_hs_prev = 1'b0;
      m_mul_a = '0; m_mul_b = '0;
      m_rsp_data = '0; m_rsp_id = '0;
    end else begin
      int g;
      logic [NREQ-1:0] exp_rv;
      logic exp_busy;
      exp_t e;
      cyc++;
      g = -1;
      if (!hold)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      m_gnt = '0;
      if (g >= 0) m_gnt[g] = 1'b1;
      checks++;
      if (rq.req_ready !== m_gnt) begin
        errors++;
        $display("FAIL mon_ready cyc=%0d got %b want %b", cyc, rq.req_ready, m_gnt);
      end
      if (m_hs_prev) begin m_mul_a = p_a; m_mul_b = p_b; end
      checks++;
      if ({mul_en, mul_a, mul_b} !== {m_hs_prev, m_mul_a, m_mul_b}) begin
        errors++;
        $display("FAIL mon_issue cyc=%0d got en=%b a=%0d b=%0d want en=%b a=%0d b=%0d",
                 cyc, mul_en, mul_a, mul_b, m_hs_prev, m_mul_a, m_mul_b);
      end
      exp_busy = sb.size() != 0;
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL mon_busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
      end
      exp_rv = '0;
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_rv = '0;
        exp_rv[sb[0].id] = 1'b1;
        m_rsp_data = sb[0].prod;
        m_rsp_id = IDW'(sb[0].id);
        void'(sb.pop_front());
      end
      checks++;
      if ({rq.rsp_valid, rq.rsp_data, rq.rsp_id} !== {exp_rv, m_rsp_data, m_rsp_id}) begin
        errors++;
        $display("FAIL mon_rsp cyc=%0d got v=%b d=%0d id=%0d want v=%b d=%0d id=%0d",
                 cyc, rq.rsp_valid, rq.rsp_data, rq.rsp_id, exp_rv, m_rsp_data, m_rsp_id);
      end
      m_hs_prev = g >= 0;
      if (g >= 0) begin
        p_a = op_a[g];
        p_b = op_b[g];
        e.due = cyc + LAT + 2;
        e.id = g;
        e.prod = (2*DW)'(op_a[g]) * (2*DW)'(op_b[g]);
        sb.push_back(e);
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  // Drivers (no checking)
  task automatic next_cycle(input int pv, input logic h);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (m_gnt[i]) vld[i] = 1'b0;
      if (!vld[i] && int'($urandom_range(0, 99)) < pv) begin
        vld[i] = 1'b1;
        op_a[i] = DW'($urandom_range(0, 4095));
        op_b[i] = DW'($urandom_range(0, 4095));
      end
    end
    hold = h;
    pack();
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1;
    vld = '0; hold = 1'b0; pack();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; hold = 1'b0; pack();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; vld = '1; pack();
    #2;
    checks++;
    if ({mul_a, mul_b, mul_en, rq.rsp_valid, rq.rsp_data, rq.rsp_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outs got a=%0d b=%0d en=%b v=%b d=%0d id=%0d busy=%b want all 0",
               mul_a, mul_b, mul_en, rq.rsp_valid, rq.rsp_data, rq.rsp_id, busy);
    end
    vld = '0; pack();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rq.req_ready, busy, mul_en} !== '0) begin
      errors++;
      $display("FAIL reset_idle got rdy=%b busy=%b en=%b want 0", rq.req_ready, busy, mul_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    vld = 4'b0100; op_a[2] = 12'd3329; op_b[2] = 12'd17; pack();
    @(negedge clk);
    checks++;
    if (rq.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got %b want 0100", rq.req_ready);
    end
    @(posedge clk); #1;
    vld = '0; pack();
    @(negedge clk);
    checks++;
    if ({mul_en, mul_a, mul_b} !== {1'b1, 12'd3329, 12'd17}) begin
      errors++;
      $display("FAIL single_issue got en=%b a=%0d b=%0d want 1 3329 17", mul_en, mul_a, mul_b);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rq.rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL single_early got %b want 0000", rq.rsp_valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({rq.rsp_valid, rq.rsp_id, rq.rsp_data} !== {4'b0100, 2'd2, 24'd56593}) begin
      errors++;
      $display("FAIL single_rsp got v=%b id=%0d d=%0d want 0100 2 56593",
               rq.rsp_valid, rq.rsp_id, rq.rsp_data);
    end
    drain(8);
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] e;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      next_cycle(100, 1'b0);
      @(negedge clk);
      e = NREQ'(1) << (c % NREQ);
      checks++;
      if (rq.req_ready !== e) begin
        errors++;
        $display("FAIL b2b_ready c=%0d got %b want %b", c, rq.req_ready, e);
      end
      if (c >= 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy c=%0d got %b want 1", c, busy);
        end
      end
      if (c >= 5) begin
        e = NREQ'(1) << ((c - 5) % NREQ);
        checks++;
        if (rq.rsp_valid !== e) begin
          errors++;
          $display("FAIL b2b_rsp c=%0d got %b want %b", c, rq.rsp_valid, e);
        end
      end
    end
    drain(8);
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] v [4];
    logic [NREQ-1:0] r [4];
    v = '{4'b0100, 4'b0011, 4'b0010, 4'b1111};
    r = '{4'b0100, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      vld = v[s]; pack();
      @(negedge clk);
      checks++;
      if (rq.req_ready !== r[s]) begin
        errors++;
        $display("FAIL wrap_ready s=%0d got %b want %b", s, rq.req_ready, r[s]);
      end
    end
    drain(8);
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      next_cycle(100, c >= 4 && c <= 10);
      @(negedge clk);
      if (c >= 4 && c <= 10) begin
        checks++;
        if (rq.req_ready !== '0) begin
          errors++;
          $display("FAIL hold_ready c=%0d got %b want 0000", c, rq.req_ready);
        end
      end
      if (c >= 5 && c <= 11) begin
        checks++;
        if (mul_en !== 1'b0) begin
          errors++;
          $display("FAIL hold_en c=%0d got %b want 0", c, mul_en);
        end
      end
      if (c == 8) begin
        checks++;
        if (rq.rsp_valid !== 4'b1000) begin
          errors++;
          $display("FAIL hold_drain got %b want 1000", rq.rsp_valid);
        end
      end
      if (c >= 9 && c <= 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL hold_busy c=%0d got %b want 0", c, busy);
        end
      end
      if (c == 11) begin
        checks++;
        if (rq.req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL hold_resume got %b want 0001", rq.req_ready);
        end
      end
    end
    drain(8);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    repeat (3) next_cycle(100, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({busy, mul_en} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre got busy=%b en=%b want 1 1", busy, mul_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rq.rsp_valid, busy, mul_en} !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b en=%b want 0", rq.rsp_valid, busy, mul_en);
    end
    vld = '0; pack();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (rq.rsp_valid !== '0) begin
        errors++;
        $display("FAIL mid_stale c=%0d got %b want 0000", c, rq.rsp_valid);
      end
    end
    @(posedge clk); #1;
    vld = '1; pack();
    @(negedge clk);
    checks++;
    if (rq.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first got %b want 0001", rq.req_ready);
    end
    drain(8);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++)
      next_cycle(int'($urandom_range(20, 90)), $urandom_range(0, 7) == 0);
    drain(10);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got busy=%b pending=%0d want 0 0", busy, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; vld = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    pack();
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
